// File: rtl/id_issue_ctrl_pkg.sv
// Shared definitions for the ID-stage issue controller: FSM encoding,
// default widths and the source-register field positions in an instruction.
package id_issue_ctrl_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int RF_AW_DEF   = 5;
    localparam int NUM_FWD_DEF = 3;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } id_state_e;

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forwarding select: lowest-index matching source wins; register 0 never matches.
// Build option ID_FWD_EN: forward bypass data; otherwise any match is reported as a stall hit.
module id_fwd_mux
    import id_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF,
    parameter int RF_AW   = RF_AW_DEF
) (
    input  logic [RF_AW-1:0]          addr,
    input  logic [DATA_W-1:0]         rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    input  logic [NUM_FWD*RF_AW-1:0]  fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    output logic [DATA_W-1:0]         data,
    output logic                      hit,
    output logic                      hit_is_load
);

    logic [NUM_FWD-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign match[gi] = fwd_we[gi] && (addr != '0) &&
                               (fwd_waddr[gi*RF_AW +: RF_AW] == addr);
        end
    endgenerate

`ifdef ID_FWD_EN
    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        data        = (addr == '0) ? '0 : rf_rdata;
        hit         = 1'b0;
        hit_is_load = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (match[k]) begin
                data        = fwd_wdata[k*DATA_W +: DATA_W];
                hit         = 1'b1;
                hit_is_load = fwd_is_load[k];
            end
        end
    end
`else
    // Pure interlock: every pending write to the operand stalls issue.
    logic unused_fwd;
    assign unused_fwd  = ^{fwd_is_load, fwd_wdata};
    assign data        = (addr == '0) ? '0 : rf_rdata;
    assign hit         = |match;
    assign hit_is_load = hit;
`endif

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage register, instruction buffering across stalls and operand issue control.
// Build option ID_FWD_EN selects operand forwarding; default is a pure interlock.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF,
    parameter int RF_AW   = RF_AW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      if_valid,
    input  logic [DATA_W-1:0]         if_pc,
    input  logic [31:0]               inst_rdata,
    input  logic                      rs_used,
    input  logic                      rt_used,
    output logic [RF_AW-1:0]          rf_raddr1,
    output logic [RF_AW-1:0]          rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    input  logic [NUM_FWD*RF_AW-1:0]  fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    output logic [DATA_W-1:0]         id_pc,
    output logic [31:0]               id_inst,
    output logic [DATA_W-1:0]         src1,
    output logic [DATA_W-1:0]         src2,
    output logic                      ex_valid,
    output logic                      stallreq
);

    id_state_e         state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_buf_q, inst_buf_d;

    logic hit1, hit2, hit1_is_load, hit2_is_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            inst_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    // The SRAM word is only valid for one cycle, so it is captured on entry to HOLD.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!hold) begin
            valid_d = if_valid;
            pc_d    = if_pc;
        end
        case (state_q)
            ST_RUN: begin
                if (hold && valid_q && !flush) begin
                    state_d    = ST_HOLD;
                    inst_buf_d = inst_rdata;
                end
            end
            ST_HOLD: begin
                if (!hold || flush) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign id_pc     = pc_q;
    assign id_inst   = (state_q == ST_HOLD) ? inst_buf_q : inst_rdata;
    assign rf_raddr1 = id_inst[RS_MSB:RS_LSB];
    assign rf_raddr2 = id_inst[RT_MSB:RT_LSB];

    id_fwd_mux #(
        .DATA_W (DATA_W),
        .NUM_FWD(NUM_FWD),
        .RF_AW  (RF_AW)
    ) u_fwd_rs (
        .addr       (rf_raddr1),
        .rf_rdata   (rf_rdata1),
        .fwd_we     (fwd_we),
        .fwd_is_load(fwd_is_load),
        .fwd_waddr  (fwd_waddr),
        .fwd_wdata  (fwd_wdata),
        .data       (src1),
        .hit        (hit1),
        .hit_is_load(hit1_is_load)
    );

    id_fwd_mux #(
        .DATA_W (DATA_W),
        .NUM_FWD(NUM_FWD),
        .RF_AW  (RF_AW)
    ) u_fwd_rt (
        .addr       (rf_raddr2),
        .rf_rdata   (rf_rdata2),
        .fwd_we     (fwd_we),
        .fwd_is_load(fwd_is_load),
        .fwd_waddr  (fwd_waddr),
        .fwd_wdata  (fwd_wdata),
        .data       (src2),
        .hit        (hit2),
        .hit_is_load(hit2_is_load)
    );

    assign stallreq = valid_q && ((rs_used && hit1 && hit1_is_load) ||
                                  (rt_used && hit2 && hit2_is_load));
    assign ex_valid = valid_q && !stallreq && !hold && !flush;

endmodule
